// File: rtl/ex_stage_ctrl_pkg.sv
// ex_ctrl_pkg: opcodes, ALU codes, FSM states and control bundles for the execute-stage controller
package ex_ctrl_pkg;
  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STOP  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_NOP   = 4'b1010;
  localparam logic [3:0] OP_BPZ   = 4'b1101;
  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_SUB   = 3'b001;
  localparam logic [2:0] ALU_OP_OR    = 3'b010;
  localparam logic [2:0] ALU_OP_NAND  = 3'b011;
  localparam logic [2:0] ALU_OP_SHIFT = 3'b100;
  localparam logic [1:0] ALU2_REG  = 2'b00;
  localparam logic [1:0] ALU2_IMM5 = 2'b10;
  localparam logic [1:0] ALU2_IMM3 = 2'b11;
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLAG_WAIT, HALT} state_t;
  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] alu2_sel;
    logic       flag_write;
    logic       alu_out_write;
    logic       mem_read;
    logic       mem_write;
    logic       mdr_load;
    logic       ir4_load;
    logic       branch_taken;
    logic       ex_stall;
    logic       halted;
  } ctrl_t;
  typedef struct packed {
    logic       alu;
    logic       load;
    logic       store;
    logic       branch;
    logic       stop;
    logic [2:0] alu_op;
    logic [1:0] alu2_sel;
  } dec_t;
  function automatic logic br_taken(logic [3:0] op, logic n, logic z);
    return op == OP_BZ ? z : op == OP_BNZ ? !z : !n;
  endfunction
endpackage

// File: rtl/ex_stage_ctrl_if.sv
// ex_stage_ctrl_if: IR3/flag inputs and registered control outputs of the execute stage
interface ex_stage_ctrl_if #(parameter int IR_W = 8);
  logic [IR_W-1:0] ir3;
  logic            ir3_valid;
  logic            n;
  logic            z;
  logic            flush;
  logic [2:0]      alu_op;
  logic [1:0]      alu2_sel;
  logic            flag_write;
  logic            alu_out_write;
  logic            mem_read;
  logic            mem_write;
  logic            mdr_load;
  logic            ir4_load;
  logic            branch_taken;
  logic            ex_stall;
  logic            halted;
  modport master (
    output ir3, ir3_valid, n, z, flush,
    input  alu_op, alu2_sel, flag_write, alu_out_write, mem_read, mem_write,
           mdr_load, ir4_load, branch_taken, ex_stall, halted
  );
  modport slave (
    input  ir3, ir3_valid, n, z, flush,
    output alu_op, alu2_sel, flag_write, alu_out_write, mem_read, mem_write,
           mdr_load, ir4_load, branch_taken, ex_stall, halted
  );
endinterface

// File: rtl/ex_stage_ctrl_decode.sv
// ex_decode: combinational opcode classification and ALU control selection
module ex_decode
  import ex_ctrl_pkg::*;
(
  input  logic [3:0] op,
  input  logic       valid,
  output dec_t       dec
);
  logic imm;
  assign imm = op[1:0] == 2'b11;
  // Classify the opcode; a bubble or unknown opcode leaves every field 0
  always_comb begin
    dec = '0;
    dec.alu = valid && (imm || op == OP_ADD || op == OP_SUB || op == OP_NAND);
    dec.load = valid && op == OP_LOAD;
    dec.store = valid && op == OP_STORE;
    dec.branch = valid && (op == OP_BZ || op == OP_BNZ || op == OP_BPZ);
    dec.stop = valid && op == OP_STOP;
    dec.alu_op = !dec.alu ? ALU_OP_ADD : imm ? (op[2] ? ALU_OP_OR : ALU_OP_SHIFT) :
                 op == OP_SUB ? ALU_OP_SUB : op == OP_NAND ? ALU_OP_NAND : ALU_OP_ADD;
    dec.alu2_sel = (!dec.alu || !imm) ? ALU2_REG : op[2] ? ALU2_IMM5 : ALU2_IMM3;
  end
endmodule

// File: rtl/ex_stage_ctrl.sv
// ex_stage_ctrl: registered execute-stage control with memory waits, branch resolution and halt
module ex_stage_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 0
) (
  input  logic         clock,
  input  logic         reset,
  ex_stage_ctrl_if.slave bus
);
  localparam int CNT_W = MEM_LAT > 0 ? $clog2(MEM_LAT + 1) : 1;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       br_op_q, br_op_d;
  ctrl_t            out_q, out_d;
  dec_t             dec;
  logic [3:0]       op;
  assign op = bus.ir3[3:0];
  ex_decode u_dec (.op(op), .valid(bus.ir3_valid), .dec(dec));
  // Next state and next registered outputs; priority halt > flush > wait states > decode
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    br_op_d = br_op_q;
    out_d = '0;
    if (state_q == HALT) begin
      out_d.halted = 1'b1;
      out_d.ex_stall = 1'b1;
    end else if (bus.flush) begin
      state_d = RUN;
      cnt_d = '0;
    end else if (state_q == MEM_WAIT) begin
      out_d.mem_read = out_q.mem_read;
      out_d.mem_write = out_q.mem_write;
      if (cnt_q == CNT_W'(1)) begin
        state_d = RUN;
        cnt_d = '0;
        out_d.mdr_load = out_q.mem_read;
        out_d.ir4_load = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
        out_d.ex_stall = 1'b1;
      end
    end else if (state_q == FLAG_WAIT) begin
      state_d = RUN;
      out_d.branch_taken = br_taken(br_op_q, bus.n, bus.z);
      out_d.ir4_load = 1'b1;
    end else if (dec.alu) begin
      out_d.alu_op = dec.alu_op;
      out_d.alu2_sel = dec.alu2_sel;
      out_d.flag_write = 1'b1;
      out_d.alu_out_write = 1'b1;
      out_d.ir4_load = 1'b1;
    end else if (dec.load || dec.store) begin
      out_d.mem_read = dec.load;
      out_d.mem_write = dec.store;
      if (MEM_LAT == 0) begin
        out_d.mdr_load = dec.load;
        out_d.ir4_load = 1'b1;
      end else begin
        state_d = MEM_WAIT;
        cnt_d = CNT_W'(MEM_LAT);
        out_d.ex_stall = 1'b1;
      end
    end else if (dec.branch) begin
      br_op_d = op;
      if (out_q.flag_write) begin
        state_d = FLAG_WAIT;
        out_d.ex_stall = 1'b1;
      end else begin
        out_d.branch_taken = br_taken(op, bus.n, bus.z);
        out_d.ir4_load = 1'b1;
      end
    end else if (dec.stop) begin
      state_d = HALT;
      out_d.halted = 1'b1;
      out_d.ex_stall = 1'b1;
    end
  end
  // State, counter and output registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q <= '0;
      br_op_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      br_op_q <= br_op_d;
      out_q <= out_d;
    end
  end
  assign {bus.alu_op, bus.alu2_sel, bus.flag_write, bus.alu_out_write, bus.mem_read,
          bus.mem_write, bus.mdr_load, bus.ir4_load, bus.branch_taken, bus.ex_stall,
          bus.halted} = out_q;
endmodule
